// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// FSM encoding and default operand width.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// start/busy/done handshake and operand/result bus.
// overflow exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/serial_subtractor_fsb.sv
// One-bit full subtractor: d = x - y - bin.
// Purely combinational; bout is the borrow into the next bit.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Optional signed overflow output: SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave sif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fs_d, fs_b;
  logic             last;
`ifdef SERIAL_SUB_OVF_EN
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             ov_q, ov_d;
`endif

  full_subtractor_bit u_fs (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (br_q),
    .d   (fs_d),
    .bout(fs_b)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Next state and datapath; sa doubles as the result shifter,
  // its vacated MSB receiving each difference bit.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ov_d    = ov_q;
`endif
    case (state_q)
      IDLE: begin
        if (sif.start) begin
          sa_d    = sif.a;
          sb_d    = sif.b;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          am_d    = sif.a[WIDTH-1];
          bm_d    = sif.b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = {fs_d, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = fs_b;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d  = {fs_d, sa_q[WIDTH-1:1]};
          bo_d    = fs_b;
`ifdef SERIAL_SUB_OVF_EN
          ov_d    = (am_q != bm_q) && (fs_d != am_q);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ov_q    <= ov_d;
`endif
    end
  end

  assign sif.busy       = (state_q != IDLE);
  assign sif.done       = (state_q == DONE);
  assign sif.diff       = diff_q;
  assign sif.borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign sif.overflow   = ov_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor.
// Define SERIAL_SUB_OVF_EN to also check overflow.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .sif(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           cmp = 0;
  int           bad = 0;
  int           cyc = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_d = '0;
  logic         last_bo = 1'b0;
  int           prev_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int c);
    exp_t r;
    int   ua = int'(a);
    int   ub = int'(b);
    int   sa = int'($signed(a));
    int   sb = int'($signed(b));
    int   sd = sa - sb;
    r.d   = W'(ua - ub);
    r.bo  = (ua < ub);
    r.ov  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    r.cyc = c;
    return r;
  endfunction

  // Monitor: pop and compare whenever done is presented.
  always @(negedge clk) begin
    if (rst) begin
      prev_done <= 1'b0;
    end else begin
      if (bus.done) begin
        chk("done_pulse", prev_done, 0);
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          e = q.pop_front();
          chk("diff", bus.diff, e.d);
          chk("borrow_out", bus.borrow_out, e.bo);
          chk("latency", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
          chk("overflow", bus.overflow, e.ov);
`endif
          last_d  = e.d;
          last_bo = e.bo;
        end
      end
      prev_done <= bus.done;
    end
  end

  task automatic step(bit st, logic [W-1:0] a, logic [W-1:0] b);
    @(negedge clk);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    if (st && !bus.busy && !rst) q.push_back(model(a, b, cyc + 1 + W));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 4 * W) begin
      step(0, W'($urandom), W'($urandom));
      n++;
    end
    if (q.size() != 0) begin
      cmp++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_op(logic [W-1:0] a, logic [W-1:0] b);
    step(1, a, b);
    step(0, W'($urandom), W'($urandom));
    chk("busy_rise", bus.busy, 1);
    drain();
    repeat (3) step(0, W'($urandom), W'($urandom));
    chk("hold_diff", bus.diff, last_d);
    chk("hold_borrow", bus.borrow_out, last_bo);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow_out, 0);
    rst = 1'b0;

    run_op(8'd13, 8'd5);
    run_op(8'd5, 8'd13);
    run_op(8'd0, 8'd1);
    run_op(8'd0, 8'd0);
    run_op(8'hFF, 8'hFF);
    run_op(8'h80, 8'h01);
    run_op(8'h10, 8'h01);

    // start held high; a/b scrambled while busy
    for (int i = 0; i < 5 * (W + 2); i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      if (!bus.busy) begin
        bus.a = 8'd20;
        bus.b = 8'd3;
        q.push_back(model(8'd20, 8'd3, cyc + 1 + W));
        if (prev_acc >= 0) chk("spacing", cyc - prev_acc, W + 2);
        prev_acc = cyc;
      end else begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
    end
    bus.start = 1'b0;
    drain();

    // reset abandons an operation mid-RUN
    step(1, 8'd200, 8'd7);
    repeat (4) step(0, W'($urandom), W'($urandom));
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_diff", bus.diff, 0);
    chk("abort_borrow", bus.borrow_out, 0);
    rst = 1'b0;
    repeat (2 * W) step(0, W'($urandom), W'($urandom));
    run_op(8'd99, 8'd42);

    // random traffic with starts also fired while busy
    for (int i = 0; i < 400; i++)
      step(($urandom % 3) == 0, W'($urandom), W'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
